// File: rtl/risc_control_unit.sv
// Control unit for the small 8-bit RISC datapath: a 12-state fetch/decode/execute
// sequencer whose outputs are purely combinational in (state, instruction, zero).
module risc_control_unit #(
    parameter int word_size = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [word_size-1:0] instruction,
    input  logic                 zero,
    output logic                 Load_R0,
    output logic                 Load_R1,
    output logic                 Load_R2,
    output logic                 Load_R3,
    output logic                 Load_PC,
    output logic                 Inc_PC,
    output logic [2:0]           Sel_Bus_1_Mux,
    output logic [1:0]           Sel_Bus_2_Mux,
    output logic                 Load_IR,
    output logic                 Load_Add_R,
    output logic                 Load_Reg_Y,
    output logic                 Load_Reg_Z,
    output logic                 write,
    output logic                 halted
);

    typedef enum logic [3:0] {
        S_idle = 4'd0,
        S_fet1 = 4'd1,
        S_fet2 = 4'd2,
        S_dec  = 4'd3,
        S_ex1  = 4'd4,
        S_rd1  = 4'd5,
        S_rd2  = 4'd6,
        S_wr1  = 4'd7,
        S_wr2  = 4'd8,
        S_br1  = 4'd9,
        S_br2  = 4'd10,
        S_halt = 4'd11
    } state_t;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_NOT = 4'd4;
    localparam logic [3:0] OP_RD  = 4'd5;
    localparam logic [3:0] OP_WR  = 4'd6;
    localparam logic [3:0] OP_BR  = 4'd7;
    localparam logic [3:0] OP_BRZ = 4'd8;

    localparam logic [2:0] SEL1_PC   = 3'd4;
    localparam logic [1:0] SEL2_ALU  = 2'd0;
    localparam logic [1:0] SEL2_BUS1 = 2'd1;
    localparam logic [1:0] SEL2_MEM  = 2'd2;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  w_opcode;
    logic [1:0]  w_src;
    logic [1:0]  w_dest;
    logic        w_load_dest;
    logic [3:0]  w_load_r;

    assign w_opcode = instruction[7:4];
    assign w_src    = instruction[3:2];
    assign w_dest   = instruction[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A single "load destination" strobe is fanned out by the dest field, so at
    // most one register load can ever be active.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_load_r
            assign w_load_r[gi] = w_load_dest && (w_dest == 2'(gi));
        end
    endgenerate

    assign Load_R0 = w_load_r[0];
    assign Load_R1 = w_load_r[1];
    assign Load_R2 = w_load_r[2];
    assign Load_R3 = w_load_r[3];

    always_comb begin
        w_state_next  = r_state;
        w_load_dest   = 1'b0;
        Load_PC       = 1'b0;
        Inc_PC        = 1'b0;
        Sel_Bus_1_Mux = 3'd0;
        Sel_Bus_2_Mux = 2'd0;
        Load_IR       = 1'b0;
        Load_Add_R    = 1'b0;
        Load_Reg_Y    = 1'b0;
        Load_Reg_Z    = 1'b0;
        write         = 1'b0;
        halted        = 1'b0;

        case (r_state)
            S_idle: w_state_next = S_fet1;
            S_fet1: begin
                Sel_Bus_1_Mux = SEL1_PC;
                Sel_Bus_2_Mux = SEL2_BUS1;
                Load_Add_R    = 1'b1;
                w_state_next  = S_fet2;
            end
            S_fet2: begin
                Sel_Bus_2_Mux = SEL2_MEM;
                Load_IR       = 1'b1;
                Inc_PC        = 1'b1;
                w_state_next  = S_dec;
            end
            S_dec: begin
                case (w_opcode)
                    OP_NOP: w_state_next = S_fet1;
                    OP_ADD, OP_SUB, OP_AND: begin
                        Sel_Bus_1_Mux = {1'b0, w_src};
                        Sel_Bus_2_Mux = SEL2_BUS1;
                        Load_Reg_Y    = 1'b1;
                        w_state_next  = S_ex1;
                    end
                    OP_NOT: begin
                        Sel_Bus_1_Mux = {1'b0, w_src};
                        Sel_Bus_2_Mux = SEL2_ALU;
                        Load_Reg_Z    = 1'b1;
                        w_load_dest   = 1'b1;
                        w_state_next  = S_fet1;
                    end
                    OP_RD, OP_WR, OP_BR: begin
                        Sel_Bus_1_Mux = SEL1_PC;
                        Sel_Bus_2_Mux = SEL2_BUS1;
                        Load_Add_R    = 1'b1;
                        if (w_opcode == OP_RD)      w_state_next = S_rd1;
                        else if (w_opcode == OP_WR) w_state_next = S_wr1;
                        else                        w_state_next = S_br1;
                    end
                    OP_BRZ: begin
                        if (zero) begin
                            Sel_Bus_1_Mux = SEL1_PC;
                            Sel_Bus_2_Mux = SEL2_BUS1;
                            Load_Add_R    = 1'b1;
                            w_state_next  = S_br1;
                        end else begin
                            // Not taken: step the PC over the branch target word.
                            Inc_PC       = 1'b1;
                            w_state_next = S_fet1;
                        end
                    end
                    default: w_state_next = S_halt;
                endcase
            end
            S_ex1: begin
                Sel_Bus_1_Mux = {1'b0, w_dest};
                Sel_Bus_2_Mux = SEL2_ALU;
                Load_Reg_Z    = 1'b1;
                w_load_dest   = 1'b1;
                w_state_next  = S_fet1;
            end
            S_rd1, S_wr1: begin
                Sel_Bus_2_Mux = SEL2_MEM;
                Load_Add_R    = 1'b1;
                Inc_PC        = 1'b1;
                w_state_next  = (r_state == S_rd1) ? S_rd2 : S_wr2;
            end
            S_rd2: begin
                Sel_Bus_2_Mux = SEL2_MEM;
                w_load_dest   = 1'b1;
                w_state_next  = S_fet1;
            end
            S_wr2: begin
                Sel_Bus_1_Mux = {1'b0, w_src};
                write         = 1'b1;
                w_state_next  = S_fet1;
            end
            S_br1: begin
                Sel_Bus_2_Mux = SEL2_MEM;
                Load_Add_R    = 1'b1;
                w_state_next  = S_br2;
            end
            S_br2: begin
                Sel_Bus_2_Mux = SEL2_MEM;
                Load_PC       = 1'b1;
                w_state_next  = S_fet1;
            end
            // Halt and the four unused encodings all park in S_halt until reset.
            default: begin
                halted       = 1'b1;
                w_state_next = S_halt;
            end
        endcase
    end

endmodule

// File: tb/tb_risc_control_unit.sv
// Directed bench for risc_control_unit: walks instruction sequences cycle by
// cycle and compares the full output vector against hand-derived constants.
module tb_risc_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] instruction;
    logic       zero;
    logic       Load_R0, Load_R1, Load_R2, Load_R3;
    logic       Load_PC, Inc_PC;
    logic [2:0] Sel_Bus_1_Mux;
    logic [1:0] Sel_Bus_2_Mux;
    logic       Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z, write, halted;

    int errors = 0;
    int checks = 0;

    risc_control_unit #(.word_size(8)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .zero(zero),
        .Load_R0(Load_R0), .Load_R1(Load_R1), .Load_R2(Load_R2), .Load_R3(Load_R3),
        .Load_PC(Load_PC), .Inc_PC(Inc_PC),
        .Sel_Bus_1_Mux(Sel_Bus_1_Mux), .Sel_Bus_2_Mux(Sel_Bus_2_Mux),
        .Load_IR(Load_IR), .Load_Add_R(Load_Add_R), .Load_Reg_Y(Load_Reg_Y),
        .Load_Reg_Z(Load_Reg_Z), .write(write), .halted(halted)
    );

    always #5 clk = ~clk;

    // {ldR3..ldR0, ldPC, incPC, sel1[2:0], sel2[1:0], ldIR, ldAddR, ldY, ldZ, write, halted}
    logic [16:0] obs;
    assign obs = {Load_R3, Load_R2, Load_R1, Load_R0, Load_PC, Inc_PC,
                  Sel_Bus_1_Mux, Sel_Bus_2_Mux, Load_IR, Load_Add_R,
                  Load_Reg_Y, Load_Reg_Z, write, halted};

    function automatic logic [16:0] mk(input logic [3:0] ldr, input logic pc,
                                       input logic inc, input logic [2:0] s1,
                                       input logic [1:0] s2, input logic ir,
                                       input logic add, input logic y,
                                       input logic z, input logic wr,
                                       input logic h);
        return {ldr, pc, inc, s1, s2, ir, add, y, z, wr, h};
    endfunction

    localparam logic [16:0] E_NONE = 17'd0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [16:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp_v);
        end
        $display("check %-12s obs=%05h exp=%05h", tag, obs, exp_v);
    endtask

    task automatic fetch(input string tag);
        chk({tag, "_fet1"}, mk(4'b0000, 0, 0, 3'd4, 2'd1, 0, 1, 0, 0, 0, 0));
        step();
        chk({tag, "_fet2"}, mk(4'b0000, 0, 1, 3'd0, 2'd2, 1, 0, 0, 0, 0, 0));
    endtask

    initial begin
        rst = 1'b1;
        instruction = 8'h00;
        zero = 1'b0;
        step();
        step();
        chk("rst_held", E_NONE);
        rst = 1'b0;
        chk("idle", E_NONE);
        step();

        // ADD R2,R1: src=2, dest=1
        fetch("add");
        instruction = 8'h19;
        step(); chk("add_dec", mk(4'b0000, 0, 0, 3'd2, 2'd1, 0, 0, 1, 0, 0, 0));
        step(); chk("add_ex1", mk(4'b0010, 0, 0, 3'd1, 2'd0, 0, 0, 0, 1, 0, 0));
        step();

        // SUB src=2, dest=3
        fetch("sub");
        instruction = 8'h2B;
        step(); chk("sub_dec", mk(4'b0000, 0, 0, 3'd2, 2'd1, 0, 0, 1, 0, 0, 0));
        step(); chk("sub_ex1", mk(4'b1000, 0, 0, 3'd3, 2'd0, 0, 0, 0, 1, 0, 0));
        step();

        // RD into R3
        fetch("rd");
        instruction = 8'h53;
        step(); chk("rd_dec", mk(4'b0000, 0, 0, 3'd4, 2'd1, 0, 1, 0, 0, 0, 0));
        step(); chk("rd_rd1", mk(4'b0000, 0, 1, 3'd0, 2'd2, 0, 1, 0, 0, 0, 0));
        step(); chk("rd_rd2", mk(4'b1000, 0, 0, 3'd0, 2'd2, 0, 0, 0, 0, 0, 0));
        step();

        // NOP
        fetch("nop");
        instruction = 8'h00;
        step(); chk("nop_dec", E_NONE);
        step();

        // NOT src=3, dest=2
        fetch("not");
        instruction = 8'h4E;
        step(); chk("not_dec", mk(4'b0100, 0, 0, 3'd3, 2'd0, 0, 0, 0, 1, 0, 0));
        step();

        // WR src=1
        fetch("wr");
        instruction = 8'h64;
        step(); chk("wr_dec", mk(4'b0000, 0, 0, 3'd4, 2'd1, 0, 1, 0, 0, 0, 0));
        step(); chk("wr_wr1", mk(4'b0000, 0, 1, 3'd0, 2'd2, 0, 1, 0, 0, 0, 0));
        step(); chk("wr_wr2", mk(4'b0000, 0, 0, 3'd1, 2'd0, 0, 0, 0, 0, 1, 0));
        step();

        // BRZ not taken
        fetch("brzn");
        instruction = 8'h80;
        zero = 1'b0;
        step(); chk("brzn_dec", mk(4'b0000, 0, 1, 3'd0, 2'd0, 0, 0, 0, 0, 0, 0));
        step();

        // BRZ taken
        fetch("brzt");
        zero = 1'b1;
        step(); chk("brzt_dec", mk(4'b0000, 0, 0, 3'd4, 2'd1, 0, 1, 0, 0, 0, 0));
        step(); chk("brzt_br1", mk(4'b0000, 0, 0, 3'd0, 2'd2, 0, 1, 0, 0, 0, 0));
        step(); chk("brzt_br2", mk(4'b0000, 1, 0, 3'd0, 2'd2, 0, 0, 0, 0, 0, 0));
        zero = 1'b0;
        step();

        // BR unconditional
        fetch("br");
        instruction = 8'h70;
        step(); chk("br_dec", mk(4'b0000, 0, 0, 3'd4, 2'd1, 0, 1, 0, 0, 0, 0));
        step(); chk("br_br1", mk(4'b0000, 0, 0, 3'd0, 2'd2, 0, 1, 0, 0, 0, 0));
        step(); chk("br_br2", mk(4'b0000, 1, 0, 3'd0, 2'd2, 0, 0, 0, 0, 0, 0));
        step();

        // Reset during S_wr1: write must never appear
        fetch("wrrst");
        instruction = 8'h64;
        step(); chk("wrrst_dec", mk(4'b0000, 0, 0, 3'd4, 2'd1, 0, 1, 0, 0, 0, 0));
        step(); chk("wrrst_wr1", mk(4'b0000, 0, 1, 3'd0, 2'd2, 0, 1, 0, 0, 0, 0));
        rst = 1'b1;
        step(); chk("wrrst_idle", E_NONE);
        rst = 1'b0;
        chk("wrrst_idle2", E_NONE);
        step();

        // Illegal opcode -> halt, held for 10 cycles, cleared by reset
        fetch("ill");
        instruction = 8'hF0;
        step(); chk("ill_dec", E_NONE);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("halt", mk(4'b0000, 0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 1));
        end
        rst = 1'b1;
        step(); chk("halt_rst", E_NONE);
        rst = 1'b0;
        step();

        // Second illegal opcode (lowest illegal value) also halts
        fetch("ill9");
        instruction = 8'h90;
        step(); chk("ill9_dec", E_NONE);
        step(); chk("ill9_halt", mk(4'b0000, 0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/risc_control_unit.md
RISC_CONTROL_UNIT -- requirements
Module: risc_control_unit

Interface
REQ-001 Parameter word_size, default 8, instruction width in bits; encoding fields assume 8.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 instruction  input  word_size  current IR contents: [7:4] opcode, [3:2] src, [1:0] dest.
REQ-005 zero  input  1  ALU zero flag held in Reg_Z.
REQ-006 Load_R0, Load_R1, Load_R2, Load_R3  output  1 each  load register Rn from Bus_2.
REQ-007 Load_PC  output  1  load PC from Bus_2.
REQ-008 Inc_PC  output  1  increment PC.
REQ-009 Sel_Bus_1_Mux  output  3  Bus_1 source: 0=R0, 1=R1, 2=R2, 3=R3, 4=PC.
REQ-010 Sel_Bus_2_Mux  output  2  Bus_2 source: 0=alu_out, 1=Bus_1, 2=mem_word; 3 never driven.
REQ-011 Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z  output  1 each  load named register.
REQ-012 write  output  1  memory write strobe, memory[Add_R] := Bus_1.
REQ-013 halted  output  1  high while in S_halt.

Function
REQ-014 State register SHALL be 4 bits; states S_idle, S_fet1, S_fet2, S_dec, S_ex1, S_rd1, S_rd2, S_wr1, S_wr2, S_br1, S_br2, S_halt.
REQ-015 Outputs SHALL be combinational in (state, instruction, zero); any output not listed for a state SHALL be 0 and selects SHALL default to 0.
REQ-016 Opcodes SHALL be NOP=0, ADD=1, SUB=2, AND=3, NOT=4, RD=5, WR=6, BR=7, BRZ=8; opcodes 9-15 are illegal.
REQ-017 S_idle: no outputs; next S_fet1.
REQ-018 S_fet1: Sel_Bus_1_Mux=4, Sel_Bus_2_Mux=1, Load_Add_R; next S_fet2.
REQ-019 S_fet2: Sel_Bus_2_Mux=2, Load_IR, Inc_PC; next S_dec.
REQ-020 S_dec, NOP: no outputs; next S_fet1.
REQ-021 S_dec, ADD/SUB/AND: Sel_Bus_1_Mux=src, Sel_Bus_2_Mux=1, Load_Reg_Y; next S_ex1.
REQ-022 S_dec, NOT: Sel_Bus_1_Mux=src, Sel_Bus_2_Mux=0, Load_Reg_Z, Load_R[dest]; next S_fet1.
REQ-023 S_dec, RD/WR/BR: Sel_Bus_1_Mux=4, Sel_Bus_2_Mux=1, Load_Add_R; next S_rd1/S_wr1/S_br1.
REQ-024 S_dec, BRZ, zero=1: as BR, next S_br1; zero=0: Inc_PC only (skip operand), next S_fet1.
REQ-025 S_dec, illegal opcode: no outputs; next S_halt.
REQ-026 S_ex1: Sel_Bus_1_Mux=dest, Sel_Bus_2_Mux=0, Load_Reg_Z, Load_R[dest]; next S_fet1.
REQ-027 S_rd1 and S_wr1: Sel_Bus_2_Mux=2, Load_Add_R, Inc_PC; next S_rd2/S_wr2.
REQ-028 S_rd2: Sel_Bus_2_Mux=2, Load_R[dest]; next S_fet1.
REQ-029 S_wr2: Sel_Bus_1_Mux=src, write; next S_fet1.
REQ-030 S_br1: Sel_Bus_2_Mux=2, Load_Add_R; next S_br2.
REQ-031 S_br2: Sel_Bus_2_Mux=2, Load_PC; next S_fet1.
REQ-032 S_halt: halted=1, all other outputs 0; remain until rst.
REQ-033 At most one of Load_R0..Load_R3 SHALL be high in any cycle; Load_PC and Inc_PC SHALL never both be high.
REQ-034 Unreachable state encodings SHALL behave as S_halt.
REQ-035 Cycle counts: NOP 3, NOT 3, ALU op 4, RD/WR/BR 5, BRZ not-taken 3, BRZ taken 5 (counting from S_fet1).

Reset
REQ-036 rst=1 at a rising edge SHALL force state S_idle regardless of current state, including mid-instruction and S_halt.
REQ-037 While state is S_idle all outputs SHALL be 0 (selects 0, halted 0); first S_fet1 is the cycle after rst deasserts.

Verification
REQ-038 Reset then idle: rst high 2 cycles, low -> S_idle one cycle, then S_fet1 with Sel_Bus_1_Mux=4, Sel_Bus_2_Mux=1, Load_Add_R=1.
REQ-039 ADD R2,R1 (instruction 0x19): S_dec Sel_Bus_1_Mux=2, Load_Reg_Y=1; S_ex1 Sel_Bus_1_Mux=1, Sel_Bus_2_Mux=0, Load_R1=1, Load_Reg_Z=1; then S_fet1.
REQ-040 RD into R3 (0x53): S_rd2 drives Sel_Bus_2_Mux=2, Load_R3=1; Inc_PC asserted in S_fet2 and S_rd1 only.
REQ-041 BRZ (0x80): zero=0 -> S_dec Inc_PC=1, next S_fet1; zero=1 -> S_br2 Load_PC=1, Inc_PC=0.
REQ-042 Illegal opcode 0xF0 -> S_halt, halted=1 held 10 cycles; rst=1 -> S_idle next edge, halted=0.
REQ-043 rst asserted during S_wr1 -> next cycle S_idle, write never asserted.
